// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : 5-stage pipeline sequencing (load-use stall, MEM branch flush,
//            data-memory wait with sticky watchdog). Optional perf counters
//            are enabled by defining HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int STALL_MAX = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              branch_taken_i,
    input  logic              mem_busy_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_hold_o,
    output logic              idex_bubble_o,
    output logic              exmem_flush_o,
    output logic              memwb_bubble_o,
    output logic [2:0]        state_o,
    output logic              watchdog_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lu_o,
    output logic [31:0]       perf_flush_o,
    output logic [31:0]       perf_wait_o
`endif
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_LU_STALL = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    localparam logic [7:0] C_STALL_MAX = 8'(STALL_MAX);
    localparam logic [7:0] C_CNT_SAT   = 8'hFF;

    state_t     r_state;
    state_t     w_action;
    state_t     w_state_nxt;
    logic       w_load_use;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_inc;
    logic       r_watchdog;

    assign w_load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                        ((ex_rd_i == id_rs1_i) ||
                         (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

    assign w_wait_cnt_inc = (r_wait_cnt == C_CNT_SAT) ? C_CNT_SAT
                                                      : r_wait_cnt + 8'd1;

    // The state register records the action chosen in the previous cycle;
    // a FLUSH just placed a bubble in ID/EX, so its load-use match is stale.
    always_comb begin
        w_action = ST_RUN;
        if (r_state == ST_INIT) begin
            w_action = ST_INIT;
        end else if (mem_busy_i) begin
            w_action = ST_MEM_WAIT;
        end else if (branch_taken_i) begin
            w_action = ST_FLUSH;
        end else if (w_load_use && (r_state != ST_FLUSH)) begin
            w_action = ST_LU_STALL;
        end
        w_state_nxt = (w_action == ST_INIT) ? ST_RUN : w_action;
    end

    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_hold_o    = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_flush_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        case (w_action)
            ST_INIT: begin
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                exmem_flush_o  = 1'b1;
                memwb_bubble_o = 1'b1;
            end
            ST_MEM_WAIT: begin
                idex_hold_o    = 1'b1;
                memwb_bubble_o = 1'b1;
            end
            ST_FLUSH: begin
                pc_write_o     = 1'b1;
                ifid_write_o   = 1'b1;
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                exmem_flush_o  = 1'b1;
            end
            ST_LU_STALL: begin
                idex_bubble_o  = 1'b1;
            end
            default: begin
                pc_write_o     = 1'b1;
                ifid_write_o   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_INIT;
            r_wait_cnt <= 8'd0;
            r_watchdog <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_action == ST_MEM_WAIT) begin
                r_wait_cnt <= w_wait_cnt_inc;
                // Set as the count reaches the limit so the flag is visible
                // during the following busy cycle.
                if (w_wait_cnt_inc == C_STALL_MAX) begin
                    r_watchdog <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    assign state_o    = r_state;
    assign watchdog_o = r_watchdog;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_perf_lu    <= 32'd0;
            r_perf_flush <= 32'd0;
            r_perf_wait  <= 32'd0;
        end else begin
            if (w_action == ST_LU_STALL) begin
                r_perf_lu <= r_perf_lu + 32'd1;
            end
            if (w_action == ST_FLUSH) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (w_action == ST_MEM_WAIT) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_lu_o    = r_perf_lu;
    assign perf_flush_o = r_perf_flush;
    assign perf_wait_o  = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Vector-table, corner-sequence and randomized model check of
//            pipe_hazard_ctrl (perf counters checked if HAZARD_PERF_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int C_STALL_MAX = 15;
    // control order: pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_flush, memwb_bubble
    localparam logic [6:0] C_INIT  = 7'b0010111;
    localparam logic [6:0] C_RUN   = 7'b1100000;
    localparam logic [6:0] C_LU    = 7'b0000100;
    localparam logic [6:0] C_WAIT  = 7'b0001001;
    localparam logic [6:0] C_FLUSH = 7'b1110110;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic       mrd;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [6:0] ctl;
        logic [2:0] st;
        logic       wd;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic       id_uses_rs2_i = 1'b0, ex_mem_read_i = 1'b0;
    logic       branch_taken_i = 1'b0, mem_busy_i = 1'b0;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_hold_o;
    logic       idex_bubble_o, exmem_flush_o, memwb_bubble_o, watchdog_o;
    logic [2:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_o, perf_flush_o, perf_wait_o;
    int          m_lu, m_fl, m_wt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int m_state, m_cnt;
    logic m_wd;

    pipe_hazard_ctrl #(.REG_AW(5), .STALL_MAX(C_STALL_MAX)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .branch_taken_i(branch_taken_i),
        .mem_busy_i    (mem_busy_i),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_hold_o   (idex_hold_o),
        .idex_bubble_o (idex_bubble_o),
        .exmem_flush_o (exmem_flush_o),
        .memwb_bubble_o(memwb_bubble_o),
        .state_o       (state_o),
        .watchdog_o    (watchdog_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_o     (perf_lu_o),
        .perf_flush_o  (perf_flush_o),
        .perf_wait_o   (perf_wait_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input int rs1, input int rs2, input int u2, input int mrd,
                                input int rd, input int br, input int busy,
                                input logic [6:0] ctl, input int st, input int wd);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u2 = 1'(u2); v.mrd = 1'(mrd);
        v.rd = 5'(rd); v.br = 1'(br); v.busy = 1'(busy);
        v.ctl = ctl; v.st = 3'(st); v.wd = 1'(wd);
        return v;
    endfunction

    // Reference model: action index 0=INIT 1=RUN 2=LU 3=WAIT 4=FLUSH
    function automatic int model_act(input vec_t v);
        bit lu;
        lu = v.mrd && (v.rd != 0) && ((v.rd == v.rs1) || (v.u2 && (v.rd == v.rs2)));
        if (m_state == 0) return 0;
        if (v.busy) return 3;
        if (v.br) return 4;
        if (lu && m_state != 4) return 2;
        return 1;
    endfunction

    function automatic logic [6:0] ctl_of(input int act);
        case (act)
            0: return C_INIT;
            2: return C_LU;
            3: return C_WAIT;
            4: return C_FLUSH;
            default: return C_RUN;
        endcase
    endfunction

    function automatic vec_t model_exp(input vec_t v);
        vec_t r;
        r = v;
        r.ctl = ctl_of(model_act(v));
        r.st = 3'(m_state);
        r.wd = m_wd;
        return r;
    endfunction

    task automatic model_step(input vec_t v);
        int act;
        act = model_act(v);
        if (act == 3) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt == C_STALL_MAX) m_wd = 1'b1;
        end else begin
            m_cnt = 0;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (act == 2) m_lu++;
        if (act == 4) m_fl++;
        if (act == 3) m_wt++;
`endif
        m_state = (act == 0) ? 1 : act;
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_wd = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        m_lu = 0; m_fl = 0; m_wt = 0;
`endif
    endtask

    task automatic check(input string nm, input logic [6:0] ctl, input logic [2:0] st, input logic wd);
        logic [6:0] got;
        got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_hold_o,
               idex_bubble_o, exmem_flush_o, memwb_bubble_o};
        n_vec++;
        if (got !== ctl || state_o !== st || watchdog_o !== wd) begin
            n_err++;
            $display("FAIL %s: got ctl=%b state=%0d wd=%b, expected ctl=%b state=%0d wd=%b",
                     nm, got, state_o, watchdog_o, ctl, st, wd);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Called on a falling edge; drives, checks mid-phase, then advances one cycle.
    task automatic cyc(input vec_t v, input string nm);
        id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_uses_rs2_i = v.u2;
        ex_mem_read_i = v.mrd; ex_rd_i = v.rd;
        branch_taken_i = v.br; mem_busy_i = v.busy;
        #2;
        check(nm, v.ctl, v.st, v.wd);
        model_step(v);
        @(negedge clk_i);
    endtask

    // Asynchronous reset asserted between edges; state must clear at once.
    task automatic do_reset(input string nm);
        #1 rst_i = 1'b0;
        #1;
        check(nm, C_INIT, 3'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk32({nm, "_perf_lu"}, perf_lu_o, 32'd0);
        chk32({nm, "_perf_flush"}, perf_flush_o, 32'd0);
        chk32({nm, "_perf_wait"}, perf_wait_o, 32'd0);
`endif
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        vec_t tbl[19];
        vec_t v;
        //              rs1 rs2 u2 mrd rd br busy  ctl      st wd
        tbl[0]  = mk(5,  0,  0, 1,  5, 1, 1, C_INIT,  0, 0);
        tbl[1]  = mk(0,  0,  0, 0,  0, 0, 0, C_RUN,   1, 0);
        tbl[2]  = mk(5,  0,  0, 1,  5, 0, 0, C_LU,    1, 0);
        tbl[3]  = mk(0,  0,  0, 0,  0, 0, 0, C_RUN,   2, 0);
        tbl[4]  = mk(0,  0,  0, 1,  0, 0, 0, C_RUN,   1, 0);
        tbl[5]  = mk(3,  7,  0, 1,  7, 0, 0, C_RUN,   1, 0);
        tbl[6]  = mk(3,  7,  1, 1,  7, 0, 0, C_LU,    1, 0);
        tbl[7]  = mk(5,  0,  0, 1,  5, 1, 0, C_FLUSH, 2, 0);
        tbl[8]  = mk(5,  0,  0, 1,  5, 0, 0, C_RUN,   4, 0);
        tbl[9]  = mk(0,  0,  0, 0,  0, 1, 1, C_WAIT,  1, 0);
        tbl[10] = mk(0,  0,  0, 0,  0, 1, 1, C_WAIT,  3, 0);
        tbl[11] = mk(0,  0,  0, 0,  0, 1, 1, C_WAIT,  3, 0);
        tbl[12] = mk(0,  0,  0, 0,  0, 1, 1, C_WAIT,  3, 0);
        tbl[13] = mk(0,  0,  0, 0,  0, 1, 0, C_FLUSH, 3, 0);
        tbl[14] = mk(0,  0,  0, 0,  0, 0, 0, C_RUN,   4, 0);
        tbl[15] = mk(0,  0,  0, 0,  0, 0, 0, C_RUN,   1, 0);
        tbl[16] = mk(9,  0,  0, 1,  9, 0, 1, C_WAIT,  1, 0);
        tbl[17] = mk(9,  0,  0, 1,  9, 0, 0, C_LU,    3, 0);
        tbl[18] = mk(0,  0,  0, 0,  0, 0, 0, C_RUN,   2, 0);

        model_reset();
        @(negedge clk_i);
        do_reset("por");

        foreach (tbl[i]) cyc(tbl[i], $sformatf("tbl%0d", i));
`ifdef HAZARD_PERF_CNT_EN
        chk32("tbl_perf_lu", perf_lu_o, 32'd3);
        chk32("tbl_perf_flush", perf_flush_o, 32'd2);
        chk32("tbl_perf_wait", perf_wait_o, 32'd5);
`endif

        // Watchdog: 16 consecutive busy cycles, flag visible on the 16th, sticky after.
        for (int k = 1; k <= 16; k++)
            cyc(mk(0, 0, 0, 0, 0, 0, 1, C_WAIT, (k == 1) ? 1 : 3, (k == 16) ? 1 : 0),
                $sformatf("wd_busy%0d", k));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 3, 1), "wd_sticky0");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 1), "wd_sticky1");
        cyc(mk(0, 0, 0, 0, 0, 1, 1, C_WAIT, 1, 1), "midwait0");
        cyc(mk(0, 0, 0, 0, 0, 1, 1, C_WAIT, 3, 1), "midwait1");
        mem_busy_i = 1'b1;
        do_reset("rst_midwait");
        cyc(mk(0, 0, 0, 0, 0, 0, 1, C_INIT, 0, 0), "post_rst_init");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 0), "post_rst_run");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rnd_rst");
            end
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            v.u2   = 1'($urandom_range(0, 1));
            v.mrd  = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 4) == 0);
            v.busy = ($urandom_range(0, 9) < 3);
            v = model_exp(v);
            cyc(v, "rnd");
        end
`ifdef HAZARD_PERF_CNT_EN
        chk32("rnd_perf_lu", perf_lu_o, 32'(m_lu));
        chk32("rnd_perf_flush", perf_flush_o, 32'(m_fl));
        chk32("rnd_perf_wait", perf_wait_o, 32'(m_wt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB). It decides each cycle whether the PC and each pipe register advance, hold, take a bubble, or flush. It covers load-use stalls, taken-branch flushes resolved in MEM, and data-memory wait states, and it tracks wait duration with a watchdog. It sits beside the forwarding unit and drives the write-enable/clear inputs of the PC and the pipe registers.

Parameters:
REG_AW, 5, register address width
STALL_MAX, 15, consecutive MEM_WAIT cycles after which watchdog_o sets (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
id_rs1_i  in  REG_AW  rs1 field of IF/ID instruction
id_rs2_i  in  REG_AW  rs2 field of IF/ID instruction
id_uses_rs2_i  in  1  IF/ID instruction reads rs2 (R/S/B type)
ex_mem_read_i  in  1  ID/EX MemRead
ex_rd_i  in  REG_AW  ID/EX rd
branch_taken_i  in  1  EX/MEM Branch & Zero (branch in MEM, taken)
mem_busy_i  in  1  data memory not ready this cycle
pc_write_o  out  1  PC loads next value at edge
ifid_write_o  out  1  IF/ID loads at edge
ifid_flush_o  out  1  IF/ID loads NOP at edge
idex_hold_o  out  1  ID/EX and EX/MEM keep contents
idex_bubble_o  out  1  ID/EX loads all-zero controls at edge
exmem_flush_o  out  1  EX/MEM loads all-zero controls at edge
memwb_bubble_o  out  1  MEM/WB loads RegWrite=0
state_o  out  3  current FSM state
watchdog_o  out  1  sticky: memory wait exceeded STALL_MAX

Behaviour:
- FSM states: INIT=0, RUN=1, LU_STALL=2, MEM_WAIT=3, FLUSH=4. The state register holds the action taken in the previous cycle. Outputs are combinational from the state and the current inputs.
- Reset (rst_i=0, asynchronous): state=INIT, wait counter=0, watchdog_o=0.
- INIT (exactly one cycle after reset release): pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, memwb_bubble=1. Inputs are ignored. Next state is RUN.
- Action priority in every other state: MEM_WAIT > FLUSH > LU_STALL > RUN.
- load_use = ex_mem_read_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs1_i) | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
- load_use is ignored when the state is FLUSH, because ID/EX holds a bubble.
- MEM_WAIT (mem_busy_i=1):
  - pc_write=0, ifid_write=0, idex_hold=1, memwb_bubble=1.
  - branch_taken_i is ignored until busy drops.
  - The wait counter increments and saturates at 255. When counter==STALL_MAX, watchdog_o sets and stays set until reset.
- FLUSH (branch_taken_i=1, not busy):
  - pc_write=1 (PC mux selects the target).
  - ifid_flush=1, idex_bubble=1, exmem_flush=1, ifid_write=1.
  - Single cycle.
- LU_STALL (load_use=1):
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - Exactly one cycle; the next cycle re-evaluates.
- RUN: pc_write=1, ifid_write=1, all flush/bubble/hold outputs 0.
- The wait counter clears on any cycle that is not a MEM_WAIT action.
- Output exclusions:
  - ifid_write=1 and ifid_flush=1 may co-occur; flush wins in the pipe register.
  - idex_hold and idex_bubble are never both 1.
- Reset asserted mid-stall or mid-flush: all state returns immediately to INIT values.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs perf_lu_o[31:0], perf_flush_o[31:0] and perf_wait_o[31:0]. Each counts cycles spent in LU_STALL, FLUSH and MEM_WAIT actions respectively. Counters wrap at 2^32 and clear on reset; INIT cycles are not counted.
- Undefined: these ports and their registers do not exist.

Test Plan:
- Reset release → one INIT cycle with pc_write=0 and ifid_flush=idex_bubble=exmem_flush=memwb_bubble=1, then state_o=1 and pc_write=1.
- ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. Repeat with ex_rd=0 → no stall. Repeat with match on rs2 and id_uses_rs2=0 → no stall.
- branch_taken=1 together with load_use=1 → FLUSH wins (ifid_flush=idex_bubble=exmem_flush=1, pc_write=1). Next cycle load_use still asserted → no stall because state=FLUSH.
- mem_busy=1 for 4 cycles with branch_taken=1 → 4 cycles of hold (pc_write=0, idex_hold=1, memwb_bubble=1), then one FLUSH cycle, then RUN.
- mem_busy=1 for 16 cycles with STALL_MAX=15 → watchdog_o rises on the 16th busy cycle and remains 1 after busy drops, until rst_i=0.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls, 2 flushes, 5 wait cycles → perf_lu=3, perf_flush=2, perf_wait=5. Async reset mid-wait → all counters 0 and state_o=0.
